load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter width, default 8, giving bits per byte lane; data words are 4*width bits, with 4 lanes fixed.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the datapath presents an access.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts the access this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 4*width bits: store data, right-justified.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 4*width bits: extended load data, 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: misaligned or illegal-size access.
REQ-014 The block SHALL have ports mem_addr (output, 32), mem_wd (output, 4*width), mem_we (output, 1) and mem_rd (input, 4*width), connecting to the byte-addressed little-endian data memory.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WR and RESP, and SHALL assert req_ready only in IDLE; an access is accepted when req_valid and req_ready are both 1.
REQ-016 The block SHALL drive mem_addr as {req_addr[31:2],2'b00} in IDLE and as the registered aligned address in WR and RESP.
REQ-017 The block SHALL flag an error for size 11, for a half access with addr[0]=1, and for a word access with addr[1:0]!=0; an error access SHALL go IDLE->RESP with rsp_err=1, and mem_we SHALL never assert for it.
REQ-018 On an accepted load, the block SHALL select lane k=addr[1:0] for a byte or lanes 2*addr[1]..2*addr[1]+1 for a half from mem_rd in the accept cycle, sign- or zero-extend per req_unsigned, register the result, and go to RESP; the response latency is 1 cycle.
REQ-019 On an accepted store, the block SHALL merge the sized req_wdata into the mem_rd word at the addressed lanes (a word store replaces all lanes), register the merged word, and go to WR.
REQ-020 In WR, the block SHALL assert mem_we=1 for exactly one cycle, with mem_addr and mem_wd driven only from registers, then go to RESP; store response latency is 2 cycles.
REQ-021 In RESP, the block SHALL assert rsp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-022 mem_we SHALL be decoded solely from the state register (state==WR), so it is glitch-free.
REQ-023 Throughput SHALL be one access per 2 cycles for loads and errors, and one per 3 cycles for stores.
REQ-024 While req_ready=0, the block SHALL ignore req_* inputs; a held req_valid is accepted on the next IDLE cycle.

Reset
REQ-025 On rst the block SHALL go to state IDLE and clear rsp_valid, rsp_err, rsp_rdata and all internal registers to 0, so that mem_we=0 and req_ready=1 from the following cycle.
REQ-026 If rst is asserted during WR, the block SHALL still complete that cycle's write, SHALL enter IDLE at the next edge, and SHALL produce no rsp_valid.
REQ-027 If rst is asserted during RESP, the block SHALL still present that cycle's pulse and SHALL enter IDLE at the next edge.

Structure
REQ-028 A shared package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-029 Lane extract/extend and store merge SHALL live in one combinational sub-module, lsu_lane_mux.

Verification
REQ-030 The bench SHALL cover byte loads: memory word 0x10 = 0x8899AABB; lb at 0x11 -> rsp_rdata 0xFFFFFFAA one cycle after accept; lbu at 0x11 -> 0x000000AA; mem_we=0 throughout.
REQ-031 The bench SHALL cover a half store: sh at 0x12 with wdata 0x00001234 -> mem_we high exactly one cycle later with mem_addr 0x10 and mem_wd 0x1234AABB; rsp_valid 2 cycles after accept; a subsequent lw at 0x10 returns 0x1234AABB.
REQ-032 The bench SHALL cover a misaligned access: lw at 0x13 -> rsp_err=1 and rsp_rdata=0 one cycle after accept; mem_we never asserts; memory unchanged.
REQ-033 The bench SHALL cover back-to-back requests: req_valid held high across three requests (lh 0x10, sb 0x11, lw 0x10) -> accepts at cycles 0, 2 and 5, with rsp_valid pulses at 1, 4 and 6.
REQ-034 The bench SHALL cover reset mid-operation: rst high during the WR of an sw -> the write lands, no rsp_valid, req_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding and the alignment rule used to reject bad accesses.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // An access is rejected when its size is illegal or its address is not
    // naturally aligned for that size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lane[0];
            SZ_WORD: err = |lane;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath request/response bus plus the data-memory port of the LSU.
// master = datapath/memory side, slave = the load/store unit.
interface lsu_if #(parameter int width = 8);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [4*width-1:0]   req_wdata;
    logic                 rsp_valid;
    logic [4*width-1:0]   rsp_rdata;
    logic                 rsp_err;
    logic [31:0]          mem_addr;
    logic [4*width-1:0]   mem_wd;
    logic                 mem_we;
    logic [4*width-1:0]   mem_rd;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wd, mem_we,
        output mem_rd
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wd, mem_we,
        input  mem_rd
    );

endinterface

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sized store data into the word read back from memory.
module lsu_lane_mux
    import lsu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [1:0]         size,
    input  logic               is_unsigned,
    input  logic [1:0]         lane,
    input  logic [4*width-1:0] rd_word,
    input  logic [4*width-1:0] wdata,
    output logic [4*width-1:0] load_data,
    output logic [4*width-1:0] store_word
);

    localparam int W = 4 * width;

    logic [width-1:0]   byte_sel;
    logic [2*width-1:0] half_sel;

    always_comb begin
        byte_sel  = rd_word[int'(lane) * width +: width];
        half_sel  = rd_word[int'(lane[1]) * 2 * width +: 2 * width];
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{(W - width){~is_unsigned & byte_sel[width-1]}}, byte_sel};
            SZ_HALF: load_data = {{(W - 2*width){~is_unsigned & half_sel[2*width-1]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Store data is right-justified, so each lane picks its source from the
    // low lanes of wdata according to its offset within the access.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic             hit;
        logic [width-1:0] src;

        always_comb begin
            hit = 1'b0;
            src = wdata[gi*width +: width];
            case (size)
                SZ_BYTE: begin
                    hit = (lane == 2'(gi));
                    src = wdata[width-1:0];
                end
                SZ_HALF: begin
                    hit = (lane[1] == 1'(gi / 2));
                    src = wdata[(gi % 2)*width +: width];
                end
                SZ_WORD: hit = 1'b1;
                default: hit = 1'b0;
            endcase
        end

        assign store_word[gi*width +: width] = hit ? src : rd_word[gi*width +: width];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access, read-modify-write for sub-word
// stores, one-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t         state_reg, state_next;
    logic [31:0]        addr_reg, addr_next;
    logic [4*width-1:0] wd_reg, wd_next;
    logic [4*width-1:0] rdata_reg, rdata_next;
    logic               err_reg, err_next;

    logic [4*width-1:0] load_data;
    logic [4*width-1:0] store_word;
    logic [31:0]        aligned_addr;
    logic               req_err;

    assign aligned_addr = {bus.req_addr[31:2], 2'b00};
    assign req_err      = access_err(bus.req_size, bus.req_addr[1:0]);

    lsu_lane_mux #(.width(width)) u_lane_mux (
        .size        (bus.req_size),
        .is_unsigned (bus.req_unsigned),
        .lane        (bus.req_addr[1:0]),
        .rd_word     (bus.mem_rd),
        .wdata       (bus.req_wdata),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wd_next       = wd_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr_reg;
        bus.mem_wd    = wd_reg;

        case (state_reg)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.mem_addr  = aligned_addr;
                if (bus.req_valid) begin
                    addr_next = aligned_addr;
                    if (req_err) begin
                        rdata_next = '0;
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end else if (bus.req_we) begin
                        wd_next    = store_word;
                        rdata_next = '0;
                        err_next   = 1'b0;
                        state_next = ST_WR;
                    end else begin
                        rdata_next = load_data;
                        err_next   = 1'b0;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WR: begin
                // Address and data come purely from registers here.
                bus.mem_we = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wd_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wd_reg    <= wd_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses checked against a byte-array reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int width = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.width(width)) bus();

    load_store_unit #(.width(width)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory: 16 words, byte addresses 0..63.
    logic [31:0] mem [0:15];
    logic        pl_we   = 1'b0;
    logic [3:0]  pl_idx  = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_addr[5:2]] <= bus.mem_wd;
        else if (pl_we)
            mem[pl_idx] <= pl_data;
    end
    assign bus.mem_rd = mem[bus.mem_addr[5:2]];

    logic [7:0] ref_mem [0:63];
    int vectors    = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          acc_q[$];
    int          rsp_q[$];
    int          we_q[$];
    logic [31:0] rsp_data_q[$];
    logic [31:0] rsp_err_q[$];
    logic [31:0] we_addr_q[$];
    logic [31:0] we_data_q[$];

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (bus.rsp_valid) begin
            rsp_q.push_back(cyc);
            rsp_data_q.push_back(bus.rsp_rdata);
            rsp_err_q.push_back(32'(bus.rsp_err));
        end
        if (bus.mem_we) begin
            we_q.push_back(cyc);
            we_addr_q.push_back(bus.mem_addr);
            we_data_q.push_back(bus.mem_wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_q.delete(); rsp_q.delete(); we_q.delete();
        rsp_data_q.delete(); rsp_err_q.delete();
        we_addr_q.delete(); we_data_q.delete();
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        int n = nbytes(size);
        int a = int'(addr[5:0]);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int a = int'(addr[5:0]);
        for (int i = 0; i < nbytes(size); i++) ref_mem[a + i] = wdata[8*i +: 8];
    endtask

    task automatic preload(input int idx, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[4*idx + i] = w[8*i +: 8];
        pl_we = 1'b1; pl_idx = 4'(idx); pl_data = w;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    endtask

    // One isolated access; called #1 after a rising edge, returns likewise.
    task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_data);
        logic        err;
        logic        wr;
        logic [31:0] exp_data;
        int          idx;
        err      = ref_err(size, addr[1:0]);
        wr       = we && !err;
        exp_data = (err || we) ? 32'h0 : ref_load(size, uns, addr);
        got_data = 'x;
        clear_mon();
        drive_req(we, size, uns, addr, wdata);
        for (int i = 0; i < 8 && acc_q.size() == 0; i++) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (wr) ref_store(size, addr, wdata);
        idx = int'(addr[5:2]);
        check($sformatf("%s/accepts", tag), 32'(acc_q.size()), 32'd1);
        check($sformatf("%s/responses", tag), 32'(rsp_q.size()), 32'd1);
        check($sformatf("%s/writes", tag), 32'(we_q.size()), wr ? 32'd1 : 32'd0);
        if (acc_q.size() == 1 && rsp_q.size() == 1) begin
            got_data = rsp_data_q[0];
            check($sformatf("%s/latency", tag), 32'(rsp_q[0] - acc_q[0]), wr ? 32'd2 : 32'd1);
            check($sformatf("%s/rdata", tag), rsp_data_q[0], exp_data);
            check($sformatf("%s/err", tag), rsp_err_q[0], 32'(err));
        end
        if (acc_q.size() == 1 && we_q.size() == 1) begin
            check($sformatf("%s/we_cycle", tag), 32'(we_q[0] - acc_q[0]), 32'd1);
            check($sformatf("%s/we_addr", tag), we_addr_q[0], {addr[31:2], 2'b00});
            check($sformatf("%s/we_data", tag), we_data_q[0], ref_word(idx));
        end
        check($sformatf("%s/mem", tag), mem[idx], ref_word(idx));
        $display("op %-10s we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d",
                 tag, we, size, uns, addr, wdata, got_data, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] e0, e1, e2;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(4, 32'h8899_AABB);
        rst = 1'b0;
        @(negedge clk);
        check("reset/req_ready", 32'(bus.req_ready), 32'd1);
        check("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset/mem_we",    32'(bus.mem_we), 32'd0);
        check("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset/rsp_err",   32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;

        // Byte loads from word 0x10 = 0x8899AABB.
        run_op("lb_11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, d);
        check("lb_11/const", d, 32'hFFFF_FFAA);
        run_op("lbu_11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, d);
        check("lbu_11/const", d, 32'h0000_00AA);

        run_op("sh_12", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_1234, d);
        check("sh_12/mem_const", mem[4], 32'h1234_AABB);
        run_op("lw_10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, d);
        check("lw_10/const", d, 32'h1234_AABB);

        run_op("lw_13_err", 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, d);
        check("lw_13_err/rdata_const", d, 32'h0);
        run_op("size11", 1'b1, SZ_ILLEGAL, 1'b0, 32'h10, 32'hDEAD_BEEF, d);
        run_op("sh_odd", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'hFFFF, d);

        // Back-to-back with req_valid held: lh 0x10, sb 0x11, lw 0x10.
        e0 = ref_load(SZ_HALF, 1'b0, 32'h10);
        clear_mon();
        drive_req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 8 && acc_q.size() < 1; i++) @(posedge clk);
        #1 drive_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_0077);
        for (int i = 0; i < 8 && acc_q.size() < 2; i++) @(posedge clk);
        ref_store(SZ_BYTE, 32'h11, 32'h77);
        e1 = 32'h0;
        e2 = ref_word(4);
        #1 drive_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 8 && acc_q.size() < 3; i++) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b/accepts", 32'(acc_q.size()), 32'd3);
        check("b2b/responses", 32'(rsp_q.size()), 32'd3);
        if (acc_q.size() == 3 && rsp_q.size() == 3) begin
            check("b2b/acc1", 32'(acc_q[1] - acc_q[0]), 32'd2);
            check("b2b/acc2", 32'(acc_q[2] - acc_q[0]), 32'd5);
            check("b2b/rsp0", 32'(rsp_q[0] - acc_q[0]), 32'd1);
            check("b2b/rsp1", 32'(rsp_q[1] - acc_q[0]), 32'd4);
            check("b2b/rsp2", 32'(rsp_q[2] - acc_q[0]), 32'd6);
            check("b2b/lh_data", rsp_data_q[0], e0);
            check("b2b/sb_data", rsp_data_q[1], e1);
            check("b2b/lw_data", rsp_data_q[2], e2);
        end
        check("b2b/mem", mem[4], ref_word(4));
        $display("op b2b      lh/sb/lw accepts=%0d responses=%0d", acc_q.size(), rsp_q.size());

        // Reset asserted while the store sits in WR.
        clear_mon();
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D);
        for (int i = 0; i < 8 && acc_q.size() == 0; i++) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr/req_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        ref_store(SZ_WORD, 32'h20, 32'hCAFE_F00D);
        check("rst_wr/writes", 32'(we_q.size()), 32'd1);
        check("rst_wr/responses", 32'(rsp_q.size()), 32'd0);
        check("rst_wr/mem", mem[8], 32'hCAFE_F00D);
        $display("op rst_wr   sw 0x20 writes=%0d responses=%0d", we_q.size(), rsp_q.size());

        for (int n = 0; n < 250; n++) begin
            logic        we;
            logic [1:0]  size;
            logic        uns;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (size == SZ_HALF) addr[0] = 1'b0;
                if (size == SZ_WORD) addr[1:0] = 2'b00;
            end
            run_op($sformatf("rnd%0d", n), we, size, uns, addr, $urandom, d);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end

        for (int i = 0; i < 16; i++) check($sformatf("final/mem%0d", i), mem[i], ref_word(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
